// File: rtl/mac_wr_master.sv
// Write master toward a MAC: buffers write beats in a small FIFO, issues one
// request per command, then streams the command's beats once the MAC is ready.
module mac_wr_master #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iCmd_Valid,
  input  logic [31:0] iCmd_Addr,
  input  logic [3:0]  iCmd_Tag,
  input  logic [2:0]  iCmd_Id,
  input  logic [1:0]  iCmd_Len,
  input  logic [3:0]  iCmd_QoS,
  output logic        oCmd_Ready,
  input  logic        iWd_Valid,
  input  logic [31:0] iWd_Data,
  input  logic [3:0]  iWd_Mask,
  output logic        oWd_Ready,
  output logic        oMAC_ValidWr,
  output logic [31:0] oMAC_AddrWr,
  output logic [3:0]  oMAC_TagWr,
  output logic [2:0]  oMAC_IdWr,
  output logic [1:0]  oMAC_LenWr,
  output logic [3:0]  oMAC_QoSWr,
  input  logic        iMAC_ReadyWr,
  output logic [31:0] oMAC_DataWr,
  output logic [3:0]  oMAC_MaskWr,
  output logic        oMAC_EoD,
  output logic        oBusy,
  output logic        oErr
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RDY, DATA} state_e;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  mask;
  } beat_t;

  function automatic logic [2:0] len_beats(input logic [1:0] len);
    case (len)
      2'b10:   len_beats = 3'd2;
      2'b11:   len_beats = 3'd4;
      default: len_beats = 3'd1;
    endcase
  endfunction

  state_e            state_q, state_d;
  beat_t             fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              wd_ready_q;
  logic [31:0]       addr_q, addr_d;
  logic [3:0]        tag_q, tag_d, qos_q, qos_d;
  logic [2:0]        id_q, id_d;
  logic [1:0]        len_q, len_d;
  logic [2:0]        beats_q, beats_d, rem_q, rem_d, pop_n;
  logic [TO_W-1:0]   wait_q, wait_d;
  logic              push, err_d, cmd_ready;

  logic              mac_valid_q, mac_eod_q, busy_q, err_q;
  logic [31:0]       mac_addr_q, mac_data_q;
  logic [3:0]        mac_tag_q, mac_qos_q, mac_mask_q;
  logic [2:0]        mac_id_q;
  logic [1:0]        mac_len_q;

  assign push = iWd_Valid & wd_ready_q;

  // Next-state, command capture, FIFO pointer/count update
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    tag_d     = tag_q;
    id_d      = id_q;
    len_d     = len_q;
    qos_d     = qos_q;
    beats_d   = beats_q;
    rem_d     = rem_q;
    wait_d    = wait_q;
    pop_n     = 3'd0;
    err_d     = 1'b0;
    cmd_ready = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_ready = (count_q >= CNT_W'(len_beats(iCmd_Len)));
        if (iCmd_Valid && cmd_ready) begin
          addr_d  = iCmd_Addr;
          tag_d   = iCmd_Tag;
          id_d    = iCmd_Id;
          len_d   = iCmd_Len;
          qos_d   = iCmd_QoS;
          beats_d = len_beats(iCmd_Len);
          state_d = REQ;
        end
      end
      REQ: begin
        wait_d  = '0;
        state_d = WAIT_RDY;
      end
      WAIT_RDY: begin
        if (iMAC_ReadyWr) begin
          rem_d   = beats_q;
          state_d = DATA;
        end else if (wait_q == TO_W'(TIMEOUT - 1)) begin
          // Abandon the command and drop its already-buffered beats
          err_d   = 1'b1;
          pop_n   = beats_q;
          state_d = IDLE;
        end else begin
          wait_d = wait_q + TO_W'(1);
        end
      end
      DATA: begin
        pop_n = 3'd1;
        if (rem_q == 3'd1) state_d = IDLE;
        else               rem_d   = rem_q - 3'd1;
      end
      default: state_d = IDLE;
    endcase

    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_n);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop_n);
  end

  // Beat storage carries no reset; only entries covered by count are read
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= '{data: iWd_Data, mask: iWd_Mask};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wd_ready_q  <= 1'b0;
      addr_q      <= '0;
      tag_q       <= '0;
      id_q        <= '0;
      len_q       <= '0;
      qos_q       <= '0;
      beats_q     <= '0;
      rem_q       <= '0;
      wait_q      <= '0;
      mac_valid_q <= 1'b0;
      mac_addr_q  <= '0;
      mac_tag_q   <= '0;
      mac_id_q    <= '0;
      mac_len_q   <= '0;
      mac_qos_q   <= '0;
      mac_data_q  <= '0;
      mac_mask_q  <= '0;
      mac_eod_q   <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wd_ready_q  <= (count_d != CNT_W'(FIFO_DEPTH));
      addr_q      <= addr_d;
      tag_q       <= tag_d;
      id_q        <= id_d;
      len_q       <= len_d;
      qos_q       <= qos_d;
      beats_q     <= beats_d;
      rem_q       <= rem_d;
      wait_q      <= wait_d;
      // Outputs are registered from the upcoming state so they line up with it
      mac_valid_q <= (state_d == REQ);
      mac_addr_q  <= (state_d == REQ) ? addr_d : '0;
      mac_tag_q   <= (state_d == REQ) ? tag_d  : '0;
      mac_id_q    <= (state_d == REQ) ? id_d   : '0;
      mac_len_q   <= (state_d == REQ) ? len_d  : '0;
      mac_qos_q   <= (state_d == REQ) ? qos_d  : '0;
      mac_data_q  <= (state_d == DATA) ? fifo_q[rd_ptr_d].data : '0;
      mac_mask_q  <= (state_d == DATA) ? fifo_q[rd_ptr_d].mask : '0;
      mac_eod_q   <= (state_d == DATA) && (rem_d == 3'd1);
      busy_q      <= (state_d != IDLE);
      err_q       <= err_d;
    end
  end

  assign oCmd_Ready   = cmd_ready;
  assign oWd_Ready    = wd_ready_q;
  assign oMAC_ValidWr = mac_valid_q;
  assign oMAC_AddrWr  = mac_addr_q;
  assign oMAC_TagWr   = mac_tag_q;
  assign oMAC_IdWr    = mac_id_q;
  assign oMAC_LenWr   = mac_len_q;
  assign oMAC_QoSWr   = mac_qos_q;
  assign oMAC_DataWr  = mac_data_q;
  assign oMAC_MaskWr  = mac_mask_q;
  assign oMAC_EoD     = mac_eod_q;
  assign oBusy        = busy_q;
  assign oErr         = err_q;

endmodule

// File: tb/tb_mac_wr_master.sv
// Directed bench for mac_wr_master: a ready-decode vector table plus
// hand-written write, timeout, wrap and reset sequences against a beat queue.
module tb_mac_wr_master;

  localparam int DEPTH = 4;
  localparam int TMO   = 255;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        iCmd_Valid = 1'b0;
  logic [31:0] iCmd_Addr = '0;
  logic [3:0]  iCmd_Tag = '0;
  logic [2:0]  iCmd_Id = '0;
  logic [1:0]  iCmd_Len = '0;
  logic [3:0]  iCmd_QoS = '0;
  logic        oCmd_Ready;
  logic        iWd_Valid = 1'b0;
  logic [31:0] iWd_Data = '0;
  logic [3:0]  iWd_Mask = '0;
  logic        oWd_Ready;
  logic        oMAC_ValidWr;
  logic [31:0] oMAC_AddrWr;
  logic [3:0]  oMAC_TagWr;
  logic [2:0]  oMAC_IdWr;
  logic [1:0]  oMAC_LenWr;
  logic [3:0]  oMAC_QoSWr;
  logic        iMAC_ReadyWr = 1'b0;
  logic [31:0] oMAC_DataWr;
  logic [3:0]  oMAC_MaskWr;
  logic        oMAC_EoD;
  logic        oBusy;
  logic        oErr;

  mac_wr_master #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .iCmd_Valid(iCmd_Valid), .iCmd_Addr(iCmd_Addr), .iCmd_Tag(iCmd_Tag),
    .iCmd_Id(iCmd_Id), .iCmd_Len(iCmd_Len), .iCmd_QoS(iCmd_QoS),
    .oCmd_Ready(oCmd_Ready),
    .iWd_Valid(iWd_Valid), .iWd_Data(iWd_Data), .iWd_Mask(iWd_Mask),
    .oWd_Ready(oWd_Ready),
    .oMAC_ValidWr(oMAC_ValidWr), .oMAC_AddrWr(oMAC_AddrWr), .oMAC_TagWr(oMAC_TagWr),
    .oMAC_IdWr(oMAC_IdWr), .oMAC_LenWr(oMAC_LenWr), .oMAC_QoSWr(oMAC_QoSWr),
    .iMAC_ReadyWr(iMAC_ReadyWr),
    .oMAC_DataWr(oMAC_DataWr), .oMAC_MaskWr(oMAC_MaskWr), .oMAC_EoD(oMAC_EoD),
    .oBusy(oBusy), .oErr(oErr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  mask;
  } beat_t;

  typedef struct {
    int         fill;
    logic [1:0] len;
    logic       exp_cmd;
    logic       exp_wd;
  } vec_t;

  beat_t model_q[$];
  vec_t  vecs[9];
  int    errors = 0;
  int    checks = 0;
  int    seq = 0;
  int    vw_pulses = 0;

  always @(negedge clk) if (oMAC_ValidWr) vw_pulses++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    iCmd_Valid = 1'b0;
    iWd_Valid = 1'b0;
    iMAC_ReadyWr = 1'b0;
    model_q.delete();
    #1;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    tick();
  endtask

  task automatic push_val(input logic [31:0] d, input logic [3:0] m);
    beat_t b;
    bit    room;
    b.data = d;
    b.mask = m;
    room = (model_q.size() < DEPTH);
    check("wd_ready_push", 32'(oWd_Ready), 32'(room));
    iWd_Valid = 1'b1;
    iWd_Data = d;
    iWd_Mask = m;
    if (room) model_q.push_back(b);
    tick();
    iWd_Valid = 1'b0;
  endtask

  task automatic push_beat();
    push_val({16'hBEEF, 16'(seq)}, 4'(seq * 5 + 3));
    seq++;
  endtask

  // Issue one command and follow it through REQ, WAIT_RDY and DATA
  task automatic do_write(input logic [1:0] len, input logic [31:0] addr,
                          input logic [3:0] tag, input logic [2:0] id,
                          input logic [3:0] qos, input int rdy_delay,
                          input bit push_during);
    int    nb;
    beat_t exp;
    bit    room;
    nb = (len == 2'b11) ? 4 : (len == 2'b10) ? 2 : 1;
    iCmd_Valid = 1'b1;
    iCmd_Addr = addr;
    iCmd_Tag = tag;
    iCmd_Id = id;
    iCmd_Len = len;
    iCmd_QoS = qos;
    #1;
    check("cmd_ready_idle", 32'(oCmd_Ready), 32'(model_q.size() >= nb));
    tick();
    iCmd_Valid = 1'b0;
    check("req_valid", 32'(oMAC_ValidWr), 32'd1);
    check("req_addr", oMAC_AddrWr, addr);
    check("req_tag", 32'(oMAC_TagWr), 32'(tag));
    check("req_id", 32'(oMAC_IdWr), 32'(id));
    check("req_len", 32'(oMAC_LenWr), 32'(len));
    check("req_qos", 32'(oMAC_QoSWr), 32'(qos));
    check("req_busy", 32'(oBusy), 32'd1);
    check("req_cmd_ready", 32'(oCmd_Ready), 32'd0);
    tick();
    check("wait_valid", 32'(oMAC_ValidWr), 32'd0);
    check("wait_addr", oMAC_AddrWr, 32'd0);
    check("wait_data", oMAC_DataWr, 32'd0);
    repeat (rdy_delay) tick();
    iMAC_ReadyWr = 1'b1;
    tick();
    iMAC_ReadyWr = 1'b0;
    for (int i = 0; i < nb; i++) begin
      room = (model_q.size() < DEPTH);
      exp = model_q.pop_front();
      check($sformatf("beat%0d_data", i), oMAC_DataWr, exp.data);
      check($sformatf("beat%0d_mask", i), 32'(oMAC_MaskWr), 32'(exp.mask));
      check($sformatf("beat%0d_eod", i), 32'(oMAC_EoD), 32'(i == nb - 1));
      check($sformatf("beat%0d_wd_ready", i), 32'(oWd_Ready), 32'(room));
      if (push_during && room) begin
        beat_t nbeat;
        nbeat.data = {16'hBEEF, 16'(seq)};
        nbeat.mask = 4'(seq * 5 + 3);
        seq++;
        iWd_Valid = 1'b1;
        iWd_Data = nbeat.data;
        iWd_Mask = nbeat.mask;
        model_q.push_back(nbeat);
      end else begin
        iWd_Valid = 1'b0;
      end
      tick();
    end
    iWd_Valid = 1'b0;
    check("post_data", oMAC_DataWr, 32'd0);
    check("post_eod", 32'(oMAC_EoD), 32'd0);
    check("post_busy", 32'(oBusy), 32'd0);
  endtask

  initial begin
    int v0, err_at, err_cnt, data_seen;

    vecs[0] = '{0, 2'b00, 1'b0, 1'b1};
    vecs[1] = '{1, 2'b00, 1'b1, 1'b1};
    vecs[2] = '{1, 2'b01, 1'b1, 1'b1};
    vecs[3] = '{1, 2'b10, 1'b0, 1'b1};
    vecs[4] = '{2, 2'b10, 1'b1, 1'b1};
    vecs[5] = '{2, 2'b11, 1'b0, 1'b1};
    vecs[6] = '{3, 2'b11, 1'b0, 1'b1};
    vecs[7] = '{4, 2'b11, 1'b1, 1'b0};
    vecs[8] = '{4, 2'b01, 1'b1, 1'b0};

    // Command-ready decode vs. buffered beats
    for (int v = 0; v < 9; v++) begin
      do_reset();
      if (v == 0) begin
        check("rst_busy", 32'(oBusy), 32'd0);
        check("rst_wd_ready", 32'(oWd_Ready), 32'd1);
      end
      for (int i = 0; i < vecs[v].fill; i++) push_beat();
      iCmd_Len = vecs[v].len;
      #1;
      check($sformatf("vec%0d_cmd_ready", v), 32'(oCmd_Ready), 32'(vecs[v].exp_cmd));
      check($sformatf("vec%0d_wd_ready", v), 32'(oWd_Ready), 32'(vecs[v].exp_wd));
    end

    // 64-bit write
    do_reset();
    push_val(32'hABCD_EF12, 4'b1101);
    push_val(32'hCBCD_EF12, 4'b1011);
    v0 = vw_pulses;
    do_write(2'b10, 32'h2345_F220, 4'hA, 3'b101, 4'b0110, 2, 1'b0);
    check("w64_valid_pulses", 32'(vw_pulses - v0), 32'd1);

    // Insufficient data holds the command off until 4 beats are buffered
    do_reset();
    push_beat();
    push_beat();
    iCmd_Valid = 1'b1;
    iCmd_Len = 2'b11;
    #1;
    check("short_cmd_ready2", 32'(oCmd_Ready), 32'd0);
    push_beat();
    check("short_cmd_ready3", 32'(oCmd_Ready), 32'd0);
    check("short_busy", 32'(oBusy), 32'd0);
    push_beat();
    check("short_cmd_ready4", 32'(oCmd_Ready), 32'd1);
    do_write(2'b11, 32'h0000_1000, 4'h3, 3'd2, 4'hF, 0, 1'b0);

    // Timeout with 3 beats buffered and a 2-beat command
    do_reset();
    repeat (3) push_beat();
    iCmd_Valid = 1'b1;
    iCmd_Len = 2'b10;
    iCmd_Addr = 32'h0000_2000;
    tick();
    iCmd_Valid = 1'b0;
    check("to_req_valid", 32'(oMAC_ValidWr), 32'd1);
    tick();
    err_at = -1;
    err_cnt = 0;
    data_seen = 0;
    for (int k = 1; k <= TMO + 8; k++) begin
      tick();
      if (oErr) begin
        err_cnt++;
        if (err_at < 0) err_at = k;
      end
      if (oMAC_DataWr != 32'd0 || oMAC_MaskWr != 4'd0 || oMAC_EoD) data_seen++;
    end
    check("to_err_cycle", 32'(err_at), 32'(TMO));
    check("to_err_pulses", 32'(err_cnt), 32'd1);
    check("to_no_data", 32'(data_seen), 32'd0);
    check("to_busy", 32'(oBusy), 32'd0);
    void'(model_q.pop_front());
    void'(model_q.pop_front());
    iCmd_Len = 2'b10;
    #1;
    check("to_left_len10", 32'(oCmd_Ready), 32'd0);
    iCmd_Len = 2'b00;
    #1;
    check("to_left_len00", 32'(oCmd_Ready), 32'd1);
    do_write(2'b00, 32'h0000_3000, 4'h1, 3'd1, 4'h1, 1, 1'b0);

    // Full FIFO, ignored 5th push, push+pop overlap and pointer wrap
    do_reset();
    repeat (4) push_beat();
    check("full_wd_ready", 32'(oWd_Ready), 32'd0);
    push_beat();
    for (int w = 0; w < 3; w++) begin
      do_write(2'b11, 32'h0001_0000 + 32'(w), 4'(w), 3'(w), 4'(w + 8), w, 1'b1);
      check($sformatf("wrap%0d_wd_ready", w), 32'(oWd_Ready), 32'd1);
      iCmd_Len = 2'b11;
      #1;
      check($sformatf("wrap%0d_count3", w), 32'(oCmd_Ready), 32'd0);
      while (model_q.size() < DEPTH) push_beat();
    end

    // Reset in the middle of a burst
    iCmd_Valid = 1'b1;
    iCmd_Len = 2'b11;
    tick();
    iCmd_Valid = 1'b0;
    tick();
    iMAC_ReadyWr = 1'b1;
    tick();
    iMAC_ReadyWr = 1'b0;
    tick();
    check("mid_busy_before", 32'(oBusy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_valid", 32'(oMAC_ValidWr), 32'd0);
    check("rst_mid_data", oMAC_DataWr, 32'd0);
    check("rst_mid_mask", 32'(oMAC_MaskWr), 32'd0);
    check("rst_mid_eod", 32'(oMAC_EoD), 32'd0);
    check("rst_mid_busy", 32'(oBusy), 32'd0);
    check("rst_mid_err", 32'(oErr), 32'd0);
    check("rst_mid_wd_ready", 32'(oWd_Ready), 32'd0);
    @(posedge clk);
    #2;
    check("rst_hold_eod", 32'(oMAC_EoD), 32'd0);
    reset = 1'b0;
    model_q.delete();
    tick();
    check("rst_rel_wd_ready", 32'(oWd_Ready), 32'd1);
    check("rst_rel_busy", 32'(oBusy), 32'd0);
    iCmd_Len = 2'b00;
    #1;
    check("rst_rel_empty", 32'(oCmd_Ready), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
